// File: rtl/soft_symbol_mapper.sv
// Streaming codeword-to-soft-symbol mapper. Each accepted codeword is serialised
// as LANES soft symbols per registered beat, with per-lane erasure flags and an
// end-of-codeword marker.
module soft_symbol_mapper #(
  parameter int CW_W   = 8,
  parameter int LANES  = 2,
  parameter int SYM_W  = 8,
  parameter int MAG    = 8,
  parameter int FORMAT = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CW_W-1:0]        in_cw,
  input  logic [CW_W-1:0]        in_punct,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*SYM_W-1:0] out_sym,
  output logic [LANES-1:0]       out_erase,
  output logic                   out_last
);
  localparam int BEATS = CW_W / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);
  localparam logic [SYM_W-1:0] POS_SYM  = SYM_W'(MAG);
  localparam logic [SYM_W-1:0] NEG_SYM  = SYM_W'(-MAG);
  localparam logic [SYM_W-1:0] MID_SYM  = {1'b1, {(SYM_W-1){1'b0}}};

  if (CW_W % LANES != 0) begin : g_badLanes
    $fatal(1, "soft_symbol_mapper: CW_W must be a multiple of LANES");
  end
  if (MAG >= (1 << (SYM_W - 1))) begin : g_badMag
    $fatal(1, "soft_symbol_mapper: MAG must be below 2^(SYM_W-1)");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CW_W-1:0]        r_cw;
  logic [CW_W-1:0]        r_punct;
  logic                   r_outValid;
  logic [LANES*SYM_W-1:0] r_outSym;
  logic [LANES-1:0]       r_outErase;
  logic                   r_outLast;

  logic                   w_busy;
  logic                   w_beatDone;
  logic                   w_take;
  logic [CW_W-1:0]        w_srcCw;
  logic [CW_W-1:0]        w_srcPunct;
  logic [CNT_W-1:0]       w_srcIdx;
  logic [CW_W-1:0]        w_shCw;
  logic [CW_W-1:0]        w_shPunct;
  logic [LANES*SYM_W-1:0] w_nextSym;
  logic [LANES-1:0]       w_nextErase;
  logic                   w_nextLast;

  assign w_busy     = (r_state == SHIFT);
  assign w_beatDone = r_outValid && out_ready;
  assign in_ready   = !w_busy || (w_beatDone && r_outLast);
  assign w_take     = in_valid && in_ready;

  // The next beat comes either from a freshly accepted codeword (beat 0) or
  // from the held codeword at the following beat index.
  assign w_srcCw    = w_take ? in_cw : r_cw;
  assign w_srcPunct = w_take ? in_punct : r_punct;
  assign w_srcIdx   = w_take ? '0 : (r_cnt + CNT_W'(1));
  assign w_nextLast = (w_srcIdx == LAST_IDX);

  always_comb begin
    w_nextSym   = '0;
    w_nextErase = '0;
    w_shCw      = '0;
    w_shPunct   = '0;
    for (int i = 0; i < LANES; i++) begin
      w_shCw    = w_srcCw >> (int'(w_srcIdx) * LANES + i);
      w_shPunct = w_srcPunct >> (int'(w_srcIdx) * LANES + i);
      if (w_shPunct[0]) begin
        w_nextSym[i*SYM_W +: SYM_W] = (FORMAT == 0) ? '0 : MID_SYM;
      end else if (FORMAT == 0) begin
        w_nextSym[i*SYM_W +: SYM_W] = w_shCw[0] ? NEG_SYM : POS_SYM;
      end else begin
        w_nextSym[i*SYM_W +: SYM_W] = {~w_shCw[0], POS_SYM[SYM_W-2:0]};
      end
      w_nextErase[i] = w_shPunct[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_cw       <= '0;
      r_punct    <= '0;
      r_outValid <= 1'b0;
      r_outSym   <= '0;
      r_outErase <= '0;
      r_outLast  <= 1'b0;
    end else begin
      if (w_take) begin
        r_cw    <= in_cw;
        r_punct <= in_punct;
      end
      if (w_take || (w_beatDone && !r_outLast)) begin
        r_state    <= SHIFT;
        r_cnt      <= w_srcIdx;
        r_outValid <= 1'b1;
        r_outSym   <= w_nextSym;
        r_outErase <= w_nextErase;
        r_outLast  <= w_nextLast;
      end else if (w_beatDone) begin
        r_state    <= IDLE;
        r_outValid <= 1'b0;
      end
    end
  end

  assign out_valid = r_outValid;
  assign out_sym   = r_outSym;
  assign out_erase = r_outErase;
  assign out_last  = r_outLast;
endmodule

// File: tb/tb_soft_symbol_mapper.sv
// Bench for soft_symbol_mapper: FORMAT 0 and FORMAT 1 instances share one input
// stream and are compared against table vectors and a beat-level reference model.
module tb_soft_symbol_mapper;
  localparam int CW_W  = 8;
  localparam int LANES = 2;
  localparam int SYM_W = 8;
  localparam int MAG   = 8;
  localparam int BEATS = CW_W / LANES;
  localparam int HALF  = 1 << (SYM_W - 1);
  localparam int NRAND = 40;

  typedef struct {
    logic [15:0] s0;
    logic [15:0] s1;
    logic [1:0]  er;
    logic        last;
  } beat_t;

  typedef struct {
    logic [7:0]  cw;
    logic [7:0]  punct;
    logic [15:0] exp0 [4];
    logic [15:0] exp1 [4];
    logic [1:0]  expEr [4];
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  in_cw = '0;
  logic [7:0]  in_punct = '0;
  logic        in_ready0, in_ready1, out_valid0, out_valid1, out_last0, out_last1;
  logic [15:0] out_sym0, out_sym1;
  logic [1:0]  out_erase0, out_erase1;

  int    vectors = 0;
  int    errors = 0;
  beat_t expQ[$];
  vec_t  tbl[4];

  soft_symbol_mapper #(.CW_W(CW_W), .LANES(LANES), .SYM_W(SYM_W), .MAG(MAG), .FORMAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_cw(in_cw),
    .in_punct(in_punct), .out_valid(out_valid0), .out_ready(out_ready), .out_sym(out_sym0),
    .out_erase(out_erase0), .out_last(out_last0)
  );

  soft_symbol_mapper #(.CW_W(CW_W), .LANES(LANES), .SYM_W(SYM_W), .MAG(MAG), .FORMAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_cw(in_cw),
    .in_punct(in_punct), .out_valid(out_valid1), .out_ready(out_ready), .out_sym(out_sym1),
    .out_erase(out_erase1), .out_last(out_last1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference beat k of a codeword, straight from the symbol rules.
  function automatic beat_t modelBeat(input logic [7:0] cw, input logic [7:0] pu, input int k);
    beat_t b;
    int    v0;
    int    v1;
    b.s0 = '0;
    b.s1 = '0;
    b.er = '0;
    for (int i = 0; i < LANES; i++) begin
      int pos = k * LANES + i;
      v0 = pu[pos] ? 0 : (cw[pos] ? -MAG : MAG);
      v1 = pu[pos] ? HALF : ((cw[pos] ? 0 : HALF) + (MAG % HALF));
      b.s0 = b.s0 | (16'(v0 & 255) << (SYM_W * i));
      b.s1 = b.s1 | (16'(v1 & 255) << (SYM_W * i));
      b.er[i] = pu[pos];
    end
    b.last = (k == BEATS - 1);
    return b;
  endfunction

  // Scoreboard: the queue front is the beat that must be on the outputs.
  always @(negedge clk) begin
    logic expValid;
    logic expReady;
    if (!rst_n) begin
      expQ.delete();
    end else begin
      expValid = (expQ.size() != 0);
      expReady = !expValid || ((expQ.size() == 1) && out_ready);
      checkOutput("mon_out_valid_f0", out_valid0, expValid);
      checkOutput("mon_out_valid_f1", out_valid1, expValid);
      checkOutput("mon_in_ready_f0", in_ready0, expReady);
      checkOutput("mon_in_ready_f1", in_ready1, expReady);
      if (expValid) begin
        checkOutput("mon_sym_f0", out_sym0, expQ[0].s0);
        checkOutput("mon_sym_f1", out_sym1, expQ[0].s1);
        checkOutput("mon_erase_f0", out_erase0, expQ[0].er);
        checkOutput("mon_erase_f1", out_erase1, expQ[0].er);
        checkOutput("mon_last_f0", out_last0, expQ[0].last);
        checkOutput("mon_last_f1", out_last1, expQ[0].last);
        if (out_ready) void'(expQ.pop_front());
      end
      if (in_valid && expReady) begin
        for (int k = 0; k < BEATS; k++) expQ.push_back(modelBeat(in_cw, in_punct, k));
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] cw, input logic [7:0] pu);
    bit ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_cw    = cw;
    in_punct = pu;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready0;
    end
    if (!ok) begin
      vectors++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no in_ready, expected acceptance of %h", cw);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    bit accNow;
    int sent;

    tbl[0].cw = 8'hA5; tbl[0].punct = 8'h00;
    tbl[0].exp0 = '{16'h08F8, 16'h08F8, 16'hF808, 16'hF808};
    tbl[0].exp1 = '{16'h8808, 16'h8808, 16'h0888, 16'h0888};
    tbl[0].expEr = '{2'b00, 2'b00, 2'b00, 2'b00};
    tbl[1].cw = 8'hFF; tbl[1].punct = 8'h0C;
    tbl[1].exp0 = '{16'hF8F8, 16'h0000, 16'hF8F8, 16'hF8F8};
    tbl[1].exp1 = '{16'h0808, 16'h8080, 16'h0808, 16'h0808};
    tbl[1].expEr = '{2'b00, 2'b11, 2'b00, 2'b00};
    tbl[2].cw = 8'h01; tbl[2].punct = 8'h80;
    tbl[2].exp0 = '{16'h08F8, 16'h0808, 16'h0808, 16'h0008};
    tbl[2].exp1 = '{16'h8808, 16'h8888, 16'h8888, 16'h8088};
    tbl[2].expEr = '{2'b00, 2'b00, 2'b00, 2'b10};
    tbl[3].cw = 8'h00; tbl[3].punct = 8'h00;
    tbl[3].exp0 = '{16'h0808, 16'h0808, 16'h0808, 16'h0808};
    tbl[3].exp1 = '{16'h8888, 16'h8888, 16'h8888, 16'h8888};
    tbl[3].expEr = '{2'b00, 2'b00, 2'b00, 2'b00};

    repeat (2) @(negedge clk);
    checkOutput("rst_valid", out_valid0, 1'b0);
    checkOutput("rst_sym", out_sym0, 16'h0000);
    checkOutput("rst_erase", out_erase0, 2'b00);
    checkOutput("rst_last", out_last0, 1'b0);
    rst_n = 1'b1;
    #1 checkOutput("rst_release_ready", in_ready0, 1'b1);

    for (int v = 0; v < 4; v++) begin
      applyStimulus(tbl[v].cw, tbl[v].punct);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        checkOutput($sformatf("tbl%0d_b%0d_valid", v, k), out_valid0, 1'b1);
        checkOutput($sformatf("tbl%0d_b%0d_sym_f0", v, k), out_sym0, tbl[v].exp0[k]);
        checkOutput($sformatf("tbl%0d_b%0d_sym_f1", v, k), out_sym1, tbl[v].exp1[k]);
        checkOutput($sformatf("tbl%0d_b%0d_erase", v, k), out_erase0, tbl[v].expEr[k]);
        checkOutput($sformatf("tbl%0d_b%0d_last", v, k), out_last0, (k == 3));
      end
    end

    // Back-to-back codewords with in_valid held across the boundary.
    @(posedge clk); #1;
    in_valid = 1'b1; in_cw = 8'hA5; in_punct = 8'h00;
    @(negedge clk);
    checkOutput("b2b_idle_ready", in_ready0, 1'b1);
    @(posedge clk); #1;
    in_cw = 8'h00;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("b2b_b%0d_valid", k), out_valid0, 1'b1);
      checkOutput($sformatf("b2b_b%0d_ready", k), in_ready0, (k == 3) || (k == 7));
      checkOutput($sformatf("b2b_b%0d_sym_f0", k), out_sym0, (k < 4) ? tbl[0].exp0[k] : 16'h0808);
      checkOutput($sformatf("b2b_b%0d_sym_f1", k), out_sym1, (k < 4) ? tbl[0].exp1[k] : 16'h8888);
      if (k == 3) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
    end

    // Backpressure on beat 2.
    applyStimulus(8'hA5, 8'h00);
    @(negedge clk);
    checkOutput("bp_b0_sym", out_sym0, 16'h08F8);
    @(negedge clk);
    checkOutput("bp_b1_sym", out_sym0, 16'h08F8);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_hold%0d_sym", s), out_sym0, 16'hF808);
      checkOutput($sformatf("bp_hold%0d_ready", s), in_ready0, 1'b0);
      checkOutput($sformatf("bp_hold%0d_last", s), out_last0, 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_b2_sym", out_sym0, 16'hF808);
    @(negedge clk);
    checkOutput("bp_b3_sym", out_sym0, 16'hF808);
    checkOutput("bp_b3_last", out_last0, 1'b1);

    // Reset in the middle of a codeword.
    applyStimulus(8'hA5, 8'h00);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("abort_valid", out_valid0, 1'b0);
    checkOutput("abort_last", out_last0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 checkOutput("abort_release_ready", in_ready0, 1'b1);
    checkOutput("abort_release_valid", out_valid0, 1'b0);
    applyStimulus(8'h00, 8'h00);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("post_b%0d_sym", k), out_sym0, 16'h0808);
      checkOutput($sformatf("post_b%0d_last", k), out_last0, (k == 3));
    end

    // Random codewords, punctures and downstream stalls.
    sent = 0;
    for (int cyc = 0; cyc < 4000 && (sent < NRAND || expQ.size() != 0 || in_valid); cyc++) begin
      @(negedge clk);
      accNow = in_valid && in_ready0;
      @(posedge clk); #1;
      if (accNow) begin
        sent++;
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < NRAND && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_cw    = 8'($urandom);
        in_punct = 8'($urandom & $urandom & $urandom);
      end
    end
    if (sent < NRAND || expQ.size() != 0) begin
      vectors++;
      errors++;
      $display("[TB] FAIL random_drain: got %0d sent with %0d beats pending, expected %0d and 0", sent, expQ.size(), NRAND);
    end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
